// File: rtl/osc_pkg.sv
// Shared types for the DDS oscillator: waveform mode encoding.
package osc_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    SINE   = 2'd0,
    SQUARE = 2'd1,
    SAW    = 2'd2,
    MUTE   = 2'd3
  } wave_mode_e;

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table, 2^lut_depth_log2_p+1 entries, synchronous read.
// Entry k = round(A*sin(pi*k / 2^(lut_depth_log2_p+1))), A = 2^(width_p-1)-1.
module quarter_sine_rom #(
  parameter int unsigned width_p          = 12,
  parameter int unsigned lut_depth_log2_p = 8
) (
  input  logic                      clk_i,
  input  logic                      en_i,
  input  logic [lut_depth_log2_p:0] addr_i,
  output logic [width_p-1:0]        data_o
);

  localparam int unsigned DEPTH = (1 << lut_depth_log2_p) + 1;
  localparam real         PI    = 3.14159265358979323846;

  function automatic logic [width_p-1:0] rom_entry(input int unsigned k);
    real amp;
    real x;
    amp = real'((1 << (width_p - 1)) - 1);
    x   = amp * $sin(PI * real'(k) / real'(1 << (lut_depth_log2_p + 1)));
    return width_p'($rtoi(x + 0.5));
  endfunction

  logic [width_p-1:0] rom [DEPTH];

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_rom
    assign rom[k] = rom_entry(k);
  end

  always_ff @(posedge clk_i) begin
    if (en_i) data_o <= rom[addr_i];
  end

endmodule

// File: rtl/dds_osc.sv
// DDS oscillator: phase accumulator, runtime config, two-stage sample pipeline
// (ROM read / sign-mirror mux) with a valid/ready output that stalls without losing phase.
module dds_osc
  import osc_pkg::*;
#(
  parameter int unsigned width_p          = 12,
  parameter int unsigned phase_width_p    = 24,
  parameter int unsigned lut_depth_log2_p = 8,
  parameter int unsigned tw_reset_p       = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     cfg_valid_i,
  input  logic [phase_width_p-1:0] cfg_tw_i,
  input  logic [MODE_W-1:0]        cfg_mode_i,
  input  logic                     cfg_phase_clr_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [width_p-1:0]       data_o
);

  localparam int unsigned W  = width_p;
  localparam int unsigned PW = phase_width_p;
  localparam int unsigned L  = lut_depth_log2_p;

  localparam logic [W-1:0] AMP     = W'((1 << (W - 1)) - 1);
  localparam logic [W-1:0] NEG_AMP = W'(-((1 << (W - 1)) - 1));
  localparam logic [L:0]   QUARTER = {1'b1, {L{1'b0}}};

  logic [PW-1:0] phase_q;
  logic [PW-1:0] tw_q;
  wave_mode_e    mode_q;

  logic          s1_valid_q;
  logic          s1_neg_q;
  wave_mode_e    s1_mode_q;
  logic [W-1:0]  s1_sq_q;
  logic [W-1:0]  s1_saw_q;

  logic          s1_load;
  logic          s2_load;
  logic [1:0]    quad;
  logic [L-1:0]  idx;
  logic [L:0]    rom_addr;
  logic [W-1:0]  rom_data;
  logic [W-1:0]  s2_data;

  assign s2_load = !valid_o || ready_i;
  assign s1_load = !s1_valid_q || s2_load;

  // Odd quadrants read the table mirrored about the quarter point.
  assign quad     = phase_q[PW-1 -: 2];
  assign idx      = phase_q[PW-3 -: L];
  assign rom_addr = quad[0] ? (QUARTER - {1'b0, idx}) : {1'b0, idx};

  quarter_sine_rom #(
    .width_p          (W),
    .lut_depth_log2_p (L)
  ) u_rom (
    .clk_i  (clk_i),
    .en_i   (s1_load),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    s2_data = '0;
    case (s1_mode_q)
      SINE:    s2_data = s1_neg_q ? -rom_data : rom_data;
      SQUARE:  s2_data = s1_sq_q;
      SAW:     s2_data = s1_saw_q;
      default: s2_data = '0;
    endcase
  end

  // Accumulator and config; a phase clear wins over the increment.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q <= '0;
      tw_q    <= PW'(tw_reset_p);
      mode_q  <= SINE;
    end else begin
      if (cfg_valid_i && cfg_phase_clr_i) begin
        phase_q <= '0;
      end else if (s1_load) begin
        phase_q <= phase_q + tw_q;
      end
      if (cfg_valid_i) begin
        tw_q   <= cfg_tw_i;
        mode_q <= wave_mode_e'(cfg_mode_i);
      end
    end
  end

  // Stage 1 captures mode and precomputed square/saw alongside the ROM read.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_valid_q <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_mode_q  <= SINE;
      s1_sq_q    <= '0;
      s1_saw_q   <= '0;
    end else if (s1_load) begin
      s1_valid_q <= 1'b1;
      s1_neg_q   <= quad[1];
      s1_mode_q  <= mode_q;
      s1_sq_q    <= phase_q[PW-1] ? NEG_AMP : AMP;
      s1_saw_q   <= {~phase_q[PW-1], phase_q[PW-2 -: W-1]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (s2_load) begin
      valid_o <= s1_valid_q;
      if (s1_valid_q) data_o <= s2_data;
    end
  end

endmodule

// File: tb/tb_dds_osc.sv
// Scoreboard bench for dds_osc: a sample-stream reference model pushes expected
// samples as they are generated; a monitor pops and compares on each handshake.
module tb_dds_osc;

  localparam int unsigned W   = 12;
  localparam int unsigned PW  = 16;
  localparam int unsigned L   = 6;
  localparam int unsigned TWR = 32'h1000;
  localparam int          AMP = (1 << (W - 1)) - 1;
  localparam real         PI  = 3.14159265358979323846;

  logic          clk_i           = 1'b0;
  logic          reset_ni        = 1'b0;
  logic          cfg_valid_i     = 1'b0;
  logic [PW-1:0] cfg_tw_i        = '0;
  logic [1:0]    cfg_mode_i      = '0;
  logic          cfg_phase_clr_i = 1'b0;
  logic          ready_i         = 1'b1;
  logic          valid_o;
  logic [W-1:0]  data_o;

  int vectors     = 0;
  int miscompares = 0;

  int            exp_q[$];
  int            m_inflight = 0;
  logic [PW-1:0] m_phase    = '0;
  logic [PW-1:0] m_tw       = PW'(TWR);
  logic [1:0]    m_mode     = '0;

  dds_osc #(
    .width_p          (W),
    .phase_width_p    (PW),
    .lut_depth_log2_p (L),
    .tw_reset_p       (TWR)
  ) dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .cfg_valid_i     (cfg_valid_i),
    .cfg_tw_i        (cfg_tw_i),
    .cfg_mode_i      (cfg_mode_i),
    .cfg_phase_clr_i (cfg_phase_clr_i),
    .ready_i         (ready_i),
    .valid_o         (valid_o),
    .data_o          (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ideal waveform value for a phase, from the truncated phase seen by the table.
  function automatic int ref_sample(input logic [PW-1:0] ph, input logic [1:0] mode);
    real x;
    int  j;
    case (mode)
      2'd0: begin
        j = int'(ph >> (PW - L - 2));
        x = real'(AMP) * $sin(2.0 * PI * real'(j) / real'(1 << (L + 2)));
        return (x < 0.0) ? -$rtoi(-x + 0.5) : $rtoi(x + 0.5);
      end
      2'd1:    return ph[PW-1] ? -AMP : AMP;
      2'd2:    return int'(ph >> (PW - W)) - (1 << (W - 1));
      default: return 0;
    endcase
  endfunction

  // Reference: up to two samples in flight; one is consumed per handshake and a
  // new one generated whenever room exists. Config applies to later samples.
  initial forever begin
    @(posedge clk_i or negedge reset_ni);
    if (!reset_ni) begin
      m_inflight = 0;
      m_phase    = '0;
      m_tw       = PW'(TWR);
      m_mode     = '0;
      exp_q.delete();
    end else begin
      logic gen;
      gen = 1'b0;
      if (m_inflight == 2 && ready_i) m_inflight--;
      if (m_inflight < 2) begin
        exp_q.push_back(ref_sample(m_phase, m_mode));
        m_inflight++;
        gen = 1'b1;
      end
      if (cfg_valid_i && cfg_phase_clr_i) m_phase = '0;
      else if (gen)                       m_phase = m_phase + m_tw;
      if (cfg_valid_i) begin
        m_tw   = cfg_tw_i;
        m_mode = cfg_mode_i;
      end
    end
  end

  // Monitor on the falling edge, away from the active edge.
  initial begin
    logic prev_stall;
    int   prev_data;
    prev_stall = 1'b0;
    prev_data  = 0;
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        prev_stall = 1'b0;
      end else begin
        check("valid_o", int'(valid_o), int'(m_inflight == 2));
        if (prev_stall) check("stall_hold", int'($signed(data_o)), prev_data);
        if (m_inflight == 2 && ready_i) begin
          if (exp_q.size() != 0) begin
            check("data_o", int'($signed(data_o)), exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard: handshake with no expected sample at %0t", $time);
          end
        end
        prev_stall = (m_inflight == 2) && !ready_i;
        prev_data  = int'($signed(data_o));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input logic [PW-1:0] tw, input logic [1:0] mode, input logic clr);
    tick(1);
    cfg_valid_i     = 1'b1;
    cfg_tw_i        = tw;
    cfg_mode_i      = mode;
    cfg_phase_clr_i = clr;
    tick(1);
    cfg_valid_i     = 1'b0;
    cfg_phase_clr_i = 1'b0;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      ready_i         = ($urandom_range(0, 3) != 0);
      cfg_valid_i     = ($urandom_range(0, 11) == 0);
      cfg_tw_i        = PW'($urandom);
      cfg_mode_i      = 2'($urandom_range(0, 3));
      cfg_phase_clr_i = ($urandom_range(0, 3) == 0);
    end
    tick(1);
    cfg_valid_i     = 1'b0;
    cfg_phase_clr_i = 1'b0;
    ready_i         = 1'b1;
  endtask

  initial begin
    #3;
    check("reset_valid", int'(valid_o), 0);
    check("reset_data", int'(data_o), 0);
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    tick(1);
    check("valid_edge1", int'(valid_o), 0);
    tick(1);
    check("valid_edge2", int'(valid_o), 1);

    cfg(16'h4000, 2'd0, 1'b1);
    tick(8);
    cfg(16'h4000, 2'd1, 1'b0);
    tick(8);
    cfg(16'h4000, 2'd2, 1'b0);
    tick(8);

    // Stall mid-stream, switching to mute while two sine samples are in flight.
    cfg(16'h4000, 2'd0, 1'b1);
    tick(6);
    ready_i = 1'b0;
    tick(2);
    cfg(16'h4000, 2'd3, 1'b0);
    tick(1);
    ready_i = 1'b1;
    tick(8);

    run_random(300);

    // Asynchronous reset between clock edges.
    #2 reset_ni = 1'b0;
    #1;
    check("async_rst_valid", int'(valid_o), 0);
    check("async_rst_data", int'(data_o), 0);
    tick(2);
    reset_ni = 1'b1;
    tick(10);

    run_random(200);
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dds_osc.md
# dds_osc

Parametrised direct-digital-synthesis oscillator. It produces a signed audio sample stream from a phase accumulator whose tuning word, waveform mode and phase can be changed at runtime. A quarter-wave sine ROM, square and saw modes, and a valid/ready output handshake that stalls cleanly without losing phase. It sits between the note/voice control logic and the sample mixer/DAC path.

## Interface
- width_p, 12, sample width (signed two's complement)
- phase_width_p, 24, phase accumulator width; must be ≥ width_p and ≥ lut_depth_log2_p+2
- lut_depth_log2_p, 8, log2 of quarter-wave ROM resolution (ROM holds 2^lut_depth_log2_p+1 entries)
- tw_reset_p, 0, tuning word after reset

- clk_i  in  1  clock
- reset_ni  in  1  asynchronous, active-low reset
- cfg_valid_i  in  1  config write strobe; always accepted (no ready)
- cfg_tw_i  in  phase_width_p  tuning word (phase increment per sample)
- cfg_mode_i  in  2  wave mode: 0 sine, 1 square, 2 saw, 3 mute
- cfg_phase_clr_i  in  1  zero the accumulator on this config write
- ready_i  in  1  downstream accepts data_o
- valid_o  out  1  data_o holds a sample
- data_o  out  width_p  signed sample

## Operation
- A = 2^(width_p-1)-1. Output frequency = tw·fs / 2^phase_width_p.
- Phase register P holds the phase of the next sample. It advances by the current tuning word each time stage 1 loads. It wraps modulo 2^phase_width_p.
- Sample n after reset or phase clear carries phase n·tw (mod 2^phase_width_p).
- Phase decode: q = P[MSB:MSB-1]; idx = next lut_depth_log2_p bits below q (truncated).
- ROM entry k = round(A·sin(π·k / 2^(lut_depth_log2_p+1))), for k = 0..2^lut_depth_log2_p. Computed at elaboration with full-precision π.
- Sine:
  - q0: +rom[idx]
  - q1: +rom[2^L − idx]
  - q2: −rom[idx]
  - q3: −rom[2^L − idx]
  - Here L = lut_depth_log2_p.
- Square: +A when P MSB = 0, else −A.
- Saw: top width_p bits of P with MSB inverted, read as signed. Range −2^(width_p-1)..A.
- Mute: 0. Phase still advances.
- Config accept (cfg_valid_i = 1):
  - Tuning-word and mode registers update at the clock edge.
  - If cfg_phase_clr_i = 1, P ← 0. This overrides any increment in the same cycle.
- Mode is captured per sample when the sample enters stage 1 and travels with it. In-flight samples are never altered by later config.
- Same-cycle config and stage-1 load: the entering sample uses the old mode and phase. The increment uses the old tuning word unless the phase is cleared.

## Timing
- Pipeline:
  - S1: registered ROM read, plus quadrant, mode and square/saw precompute.
  - S2: sign/mirror mux into registered data_o.
- S2 loads when !valid_o or ready_i. S1 loads when S1 is empty or S2 loads. The generator never starves.
- After reset deasserts, valid_o rises after the 2nd rising edge. It then stays high; only stalls hold it.
- While valid_o && !ready_i, data_o stays stable and P does not advance.
- Throughput is 1 sample/cycle with ready_i held high.
- Config to output latency: the first sample reflecting new mode/tw appears on data_o 2 accepted loads after the accept edge.
- Reset (asynchronous, any time including mid-stall) sets:
  - valid_o = 0, data_o = 0, P = 0
  - tw = tw_reset_p, mode = sine
  - S1 empty

## Structure
- osc_pkg: wave_mode_e enum (SINE, SQUARE, SAW, MUTE), mode width constant.
- Sub-module quarter_sine_rom: parameters width_p, lut_depth_log2_p; synchronous read, elaboration-time init.
- dds_osc holds the accumulator, config registers, pipeline valids and output mux.

## Test plan
Test parameters: width_p = 12, phase_width_p = 16, lut_depth_log2_p = 6, A = 2047.
- Reset release, cfg tw = 0x4000 sine with phase clear, ready_i = 1 -> data_o sequence 0, 2047, 0, −2047 repeating; valid_o high from the 2nd edge.
- Same tw, square -> 2047, 2047, −2047, −2047 repeating.
- Same tw, saw -> −2048, −1024, 0, 1024 repeating.
- ready_i low for 5 cycles mid-stream -> data_o frozen; after release the sequence resumes with no skipped or repeated sample.
- Mode change to mute during stall, with 2 sine samples in flight -> those 2 sine samples emitted first, then 0s.
- Assert reset_ni low asynchronously mid-stream -> valid_o and data_o go to 0 without a clock edge; after release, phase restarts at 0 with tw = tw_reset_p.
